div_unit: RTL and testbench

Multi-cycle 32-bit integer divider serving the EX stage for DIV/DIVU. EX is the initiator: it raises a start request with operands and a signed flag, then holds the request until the divider signals ready. The divider is the responder: it computes quotient and remainder in 32 iterations of restoring division and returns them packed for the HI/LO write path. An annul input lets EX cancel an in-flight divide on a flush or exception.

---
 rtl/div_unit.sv | 148 ++++++++++++++
 tb/tb_div_unit.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// div_unit: multi-cycle restoring divider for DIV/DIVU in the EX stage.
// It returns {remainder, quotient} packed for the HI/LO write path and
// supports cancellation of an in-flight divide through annul_i.
module div_unit #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o
);

    typedef enum logic [1:0] {
        ST_FREE   = 2'd0,
        ST_BYZERO = 2'd1,
        ST_ON     = 2'd2,
        ST_END    = 2'd3
    } state_t;

    localparam logic [DATA_W-1:0] ONE      = DATA_W'(1);
    localparam logic [DATA_W-1:0] ZERO     = '0;
    localparam logic [5:0]        LAST_CNT = 6'(DATA_W);

    state_t              state;
    logic [5:0]          cnt;
    logic [2*DATA_W:0]   dividend;
    logic [DATA_W-1:0]   divisor;
    logic                sign_flag;
    logic                dvd_neg;
    logic                dvs_neg;

    logic [DATA_W-1:0]   dvd_abs;
    logic [DATA_W-1:0]   dvs_abs;
    logic [DATA_W:0]     diff;
    logic [DATA_W-1:0]   quot_raw;
    logic [DATA_W-1:0]   rem_raw;
    logic [DATA_W-1:0]   quot_fin;
    logic [DATA_W-1:0]   rem_fin;

    // Operand magnitudes, the trial subtraction and the sign fix-up of the final result.
    // The register holds {partial remainder, dividend bits / quotient bits, spare bit};
    // the upper 33 bits are compared so a partial remainder that has grown past 32 bits
    // after the shift is still handled for divisors near 2^32.
    always_comb begin
        dvd_abs  = opdata1_i;
        dvs_abs  = opdata2_i;
        if (signed_div_i && opdata1_i[DATA_W-1]) begin
            dvd_abs = ~opdata1_i + ONE;
        end
        if (signed_div_i && opdata2_i[DATA_W-1]) begin
            dvs_abs = ~opdata2_i + ONE;
        end

        diff     = dividend[2*DATA_W:DATA_W] - {1'b0, divisor};
        quot_raw = dividend[DATA_W-1:0];
        rem_raw  = dividend[2*DATA_W:DATA_W+1];
        quot_fin = quot_raw;
        rem_fin  = rem_raw;
        if (sign_flag && (dvd_neg ^ dvs_neg)) begin
            quot_fin = ~quot_raw + ONE;
        end
        if (sign_flag && dvd_neg) begin
            rem_fin = ~rem_raw + ONE;
        end
    end

    // Divider control FSM with registered result and ready.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_FREE;
            cnt       <= '0;
            dividend  <= '0;
            divisor   <= '0;
            sign_flag <= 1'b0;
            dvd_neg   <= 1'b0;
            dvs_neg   <= 1'b0;
            result_o  <= '0;
            ready_o   <= 1'b0;
        end else begin
            case (state)
                ST_FREE: begin
                    ready_o  <= 1'b0;
                    result_o <= '0;
                    if (start_i && !annul_i) begin
                        if (opdata2_i == ZERO) begin
                            state <= ST_BYZERO;
                        end else begin
                            state     <= ST_ON;
                            cnt       <= '0;
                            dividend  <= {{DATA_W{1'b0}}, dvd_abs, 1'b0};
                            divisor   <= dvs_abs;
                            sign_flag <= signed_div_i;
                            dvd_neg   <= opdata1_i[DATA_W-1];
                            dvs_neg   <= opdata2_i[DATA_W-1];
                        end
                    end
                end

                ST_BYZERO: begin
                    if (annul_i) begin
                        state <= ST_FREE;
                    end else begin
                        result_o <= '0;
                        ready_o  <= 1'b1;
                        state    <= ST_END;
                    end
                end

                ST_ON: begin
                    if (annul_i) begin
                        state    <= ST_FREE;
                        ready_o  <= 1'b0;
                        result_o <= '0;
                    end else if (cnt != LAST_CNT) begin
                        if (diff[DATA_W]) begin
                            dividend <= {dividend[2*DATA_W-1:0], 1'b0};
                        end else begin
                            dividend <= {diff[DATA_W-1:0], dividend[DATA_W-1:0], 1'b1};
                        end
                        cnt <= cnt + 6'd1;
                    end else begin
                        result_o <= {rem_fin, quot_fin};
                        ready_o  <= 1'b1;
                        state    <= ST_END;
                    end
                end

                ST_END: begin
                    if (!start_i) begin
                        state    <= ST_FREE;
                        ready_o  <= 1'b0;
                        result_o <= '0;
                    end
                end

                default: begin
                    state <= ST_FREE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed, table-driven bench for div_unit plus hand-written
// sequences for annul, start+annul collision, and asynchronous reset.
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int n_cmp;
    int n_err;

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs [10];

    div_unit #(.DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Record one comparison and report it if it does not match.
    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    // Issue one request, measure edges until ready (start edge counts as 1),
    // check result, hold while start stays high, then retire it.
    task automatic apply_stimulus(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                  input logic [63:0] exp, input int lat, input string name);
        int edges;
        @(negedge clk);
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        @(posedge clk);
        #1;
        edges = 1;
        opdata1_i    = ~a;
        opdata2_i    = 32'h0;
        signed_div_i = ~sgn;
        while (!ready_o && edges < 100) begin
            @(posedge clk);
            #1;
            edges++;
        end
        check_output({name, " latency"}, 64'(edges), 64'(lat));
        check_output({name, " result"}, result_o, exp);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check_output({name, " hold"}, {63'b0, ready_o} ^ result_o, {63'b0, 1'b1} ^ exp);
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk);
        #1;
        check_output({name, " clear result"}, result_o, 64'h0);
        check_output({name, " clear ready"}, {63'b0, ready_o}, 64'h0);
    endtask

    // Watch for a number of edges and count any cycle in which ready is seen.
    task automatic expect_no_ready(input int cycles, input string name);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (ready_o) seen++;
        end
        check_output({name, " ready never rose"}, 64'(seen), 64'h0);
        check_output({name, " result idle"}, result_o, 64'h0);
    endtask

    // Main test sequence.
    initial begin
        n_cmp        = 0;
        n_err        = 0;
        rst          = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i    = 32'h0;
        opdata2_i    = 32'h0;
        start_i      = 1'b0;
        annul_i      = 1'b0;

        vecs[0] = '{1'b0, 32'd100,        32'd7,        64'h00000002_0000000E, 34};
        vecs[1] = '{1'b1, 32'hFFFFFFF9,   32'h00000002, 64'hFFFFFFFF_FFFFFFFD, 34};
        vecs[2] = '{1'b1, 32'h00000007,   32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 34};
        vecs[3] = '{1'b1, 32'h80000000,   32'hFFFFFFFF, 64'h00000000_80000000, 34};
        vecs[4] = '{1'b0, 32'hFFFFFFFF,   32'h00000001, 64'h00000000_FFFFFFFF, 34};
        vecs[5] = '{1'b0, 32'd5,          32'd0,        64'h00000000_00000000, 2};
        vecs[6] = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFE, 64'h00000001_00000001, 34};
        vecs[7] = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9, 64'hFFFFFFFE_0000000E, 34};
        vecs[8] = '{1'b0, 32'h80000000,   32'hFFFFFFFF, 64'h80000000_00000000, 34};
        vecs[9] = '{1'b1, 32'hFFFFFFF9,   32'd0,        64'h00000000_00000000, 2};

        #23;
        check_output("reset result", result_o, 64'h0);
        check_output("reset ready", {63'b0, ready_o}, 64'h0);
        rst = 1'b1;

        for (int i = 0; i < 10; i++) begin
            apply_stimulus(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat,
                           $sformatf("vec%0d", i));
        end

        // Annul during iteration 10 of 100/7, then a full 9/3.
        $display("[TB] annul mid-divide");
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i    = 32'd100;
        opdata2_i    = 32'd7;
        start_i      = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        annul_i = 1'b1;
        start_i = 1'b0;
        @(negedge clk);
        annul_i = 1'b0;
        expect_no_ready(40, "annul");
        apply_stimulus(1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 34, "after annul");

        // Start and annul together in FREE: the request is dropped.
        $display("[TB] start with annul in FREE");
        @(negedge clk);
        opdata1_i = 32'd100;
        opdata2_i = 32'd7;
        start_i   = 1'b1;
        annul_i   = 1'b1;
        @(negedge clk);
        start_i   = 1'b0;
        annul_i   = 1'b0;
        expect_no_ready(40, "start+annul");

        // Annul while in BYZERO.
        $display("[TB] annul divide-by-zero");
        @(negedge clk);
        opdata1_i = 32'd5;
        opdata2_i = 32'd0;
        start_i   = 1'b1;
        @(negedge clk);
        start_i   = 1'b0;
        annul_i   = 1'b1;
        @(negedge clk);
        annul_i   = 1'b0;
        expect_no_ready(5, "byzero annul");

        // Asynchronous reset at iteration 20.
        $display("[TB] reset mid-divide");
        @(negedge clk);
        opdata1_i = 32'd100;
        opdata2_i = 32'd7;
        start_i   = 1'b1;
        repeat (20) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_output("async reset result", result_o, 64'h0);
        check_output("async reset ready", {63'b0, ready_o}, 64'h0);
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        expect_no_ready(40, "post reset");
        apply_stimulus(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 34, "after reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global time limit so the run always terminates.
    initial begin
        #400000;
        $display("[TB] FAIL timeout: simulation exceeded time limit");
        $fatal(1, "[TB] timeout");
    end

endmodule
